// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - job request handshake between a job source and counter_ctrl
//
// Signals:
//   req_valid  job request valid (source -> controller)
//   req_ready  controller can accept a job (controller -> source)
//   req_start  value to load into the counter
//   req_steps  number of increments to issue
// Modports:
//   master  job source side
//   slave   counter_ctrl side
interface counter_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_W     = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_start;
    logic [STEP_W-1:0]     req_steps;

    modport master (
        output req_valid,
        output req_start,
        output req_steps,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_start,
        input  req_steps,
        output req_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - sequencer and self-checker driving a loadable up-counter
//
// Accepts a job (start, steps), loads the counter, issues the increments
// (suspended while pause is high), compares the returned count against an
// internal expectation every cycle and reports the final count with a
// sticky mismatch flag.
//
// Optional feature macro: COUNTER_CTRL_ERRCNT_EN adds err_cnt, a saturating
// count of failed compares in the current job.
//
// Ports:
//   clk          clock, rising edge
//   rstN         asynchronous active-low reset
//   req_if       job request handshake (slave modport)
//   pause        suspends increments while high (RUN only)
//   load         counter load strobe
//   enable       counter increment enable
//   Data_in      value loaded into the counter
//   count        registered count returned by the counter
//   done         one-cycle pulse when a job finishes
//   mismatch     sticky per job: some compare failed
//   final_count  count sampled in CHECK
//   err_cnt      (COUNTER_CTRL_ERRCNT_EN only) failed compares this job
module counter_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    counter_ctrl_if.slave         req_if,
    input  logic                  pause,
    output logic                  load,
    output logic                  enable,
    output logic [DATA_WIDTH-1:0] Data_in,
    input  logic [DATA_WIDTH-1:0] count,
    output logic                  done,
    output logic                  mismatch,
    output logic [DATA_WIDTH-1:0] final_count
`ifdef COUNTER_CTRL_ERRCNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] start_q;
    logic [STEP_W-1:0]     steps_q;
    logic [DATA_WIDTH-1:0] exp_cnt;
    logic [STEP_W-1:0]     remaining;
    logic                  mismatch_q;
    logic [DATA_WIDTH-1:0] final_q;
    logic                  cmp_fail;

`ifdef COUNTER_CTRL_ERRCNT_EN
    logic [7:0]            err_q;
    assign err_cnt = err_q;
`endif

    // The counter registers its output, so count always reflects the
    // load/enable of the previous cycle; exp_cnt advances on the same edge.
    assign cmp_fail = (count != exp_cnt);

    // Ready is gated with rstN so it stays low throughout reset and rises
    // in the first cycle after release.
    assign req_if.req_ready = (state == S_IDLE) && rstN;
    assign load             = (state == S_LOAD);
    assign enable           = (state == S_LOAD) || ((state == S_RUN) && !pause);
    assign done             = (state == S_DONE);
    assign Data_in          = start_q;
    assign mismatch         = mismatch_q;
    assign final_count      = final_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= S_IDLE;
            start_q    <= '0;
            steps_q    <= '0;
            exp_cnt    <= '0;
            remaining  <= '0;
            mismatch_q <= 1'b0;
            final_q    <= '0;
`ifdef COUNTER_CTRL_ERRCNT_EN
            err_q      <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        start_q    <= req_if.req_start;
                        steps_q    <= req_if.req_steps;
                        mismatch_q <= 1'b0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    exp_cnt   <= start_q;
                    remaining <= steps_q;
`ifdef COUNTER_CTRL_ERRCNT_EN
                    err_q     <= 8'd0;
`endif
                    state     <= (steps_q != '0) ? S_RUN : S_CHECK;
                end
                S_RUN: begin
                    if (cmp_fail) begin
                        mismatch_q <= 1'b1;
`ifdef COUNTER_CTRL_ERRCNT_EN
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
`endif
                    end
                    if (!pause) begin
                        exp_cnt   <= exp_cnt + DATA_WIDTH'(1);
                        remaining <= remaining - STEP_W'(1);
                        if (remaining == STEP_W'(1)) state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cmp_fail) begin
                        mismatch_q <= 1'b1;
`ifdef COUNTER_CTRL_ERRCNT_EN
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
`endif
                    end
                    final_q <= count;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - scoreboard bench for counter_ctrl with a behavioural counter
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       pause = 1'b0;
    logic       load;
    logic       enable;
    logic [7:0] Data_in;
    logic [7:0] count;
    logic       done;
    logic       mismatch;
    logic [7:0] final_count;
`ifdef COUNTER_CTRL_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int skip_n = 0;
    int inc_n;

    typedef struct {
        logic [7:0] fc;
        logic       mm;
        int         lat;
        int         en;
        logic [7:0] din;
        int         ec;
    } exp_t;

    exp_t exp_q[$];

    counter_ctrl_if #(.DATA_WIDTH(8), .STEP_W(8)) req_if ();

    counter_ctrl #(.DATA_WIDTH(8), .STEP_W(8)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .req_if      (req_if),
        .pause       (pause),
        .load        (load),
        .enable      (enable),
        .Data_in     (Data_in),
        .count       (count),
        .done        (done),
        .mismatch    (mismatch),
        .final_count (final_count)
`ifdef COUNTER_CTRL_ERRCNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter model; skip_n != 0 makes it ignore that increment after a load.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= 8'd0;
            inc_n <= 0;
        end else if (load) begin
            count <= Data_in;
            inc_n <= 0;
        end else if (enable) begin
            inc_n <= inc_n + 1;
            if (skip_n == 0 || inc_n + 1 != skip_n) count <= count + 8'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: tracks the job in flight and checks it against the queue on done.
    int   acc_cyc;
    int   en_cnt;
    int   ld_cnt;
    int   pe_cnt;
    logic [7:0] ld_din;
    bit   in_job = 0;

    always @(negedge clk) begin
        #1;
        if (!rstN) begin
            in_job = 0;
        end else if (req_if.req_valid && req_if.req_ready) begin
            in_job  = 1;
            acc_cyc = cyc;
            en_cnt  = 0;
            ld_cnt  = 0;
            pe_cnt  = 0;
            ld_din  = 8'h00;
        end else if (in_job) begin
            if (enable) en_cnt++;
            if (enable && pause) pe_cnt++;
            if (load) begin
                ld_cnt++;
                ld_din = Data_in;
            end
            if (done) begin
                in_job = 0;
                if (exp_q.size() == 0) begin
                    chk("done_without_job", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("final_count", 32'(final_count), 32'(e.fc));
                    chk("mismatch", 32'(mismatch), 32'(e.mm));
                    chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    chk("enable_cycles", 32'(en_cnt), 32'(e.en));
                    chk("load_cycles", 32'(ld_cnt), 32'd1);
                    chk("load_data", 32'(ld_din), 32'(e.din));
                    chk("enable_while_paused", 32'(pe_cnt), 32'd0);
`ifdef COUNTER_CTRL_ERRCNT_EN
                    chk("err_cnt", 32'(err_cnt), 32'(e.ec));
`endif
                end
            end
        end else if (done) begin
            chk("stray_done", 32'd1, 32'd0);
        end
    end

    task automatic issue(input logic [7:0] start, input logic [7:0] steps, output int k);
        int t;
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_start = start;
        req_if.req_steps = steps;
        t = 0;
        while (!req_if.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_if.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        k = cyc;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        req_if.req_start = 8'($urandom);
        req_if.req_steps = 8'($urandom);
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic run_job(input logic [7:0] start, input logic [7:0] steps, input bit do_pause,
                           input logic [7:0] fc, input logic mm, input int lat, input int en, input int ec);
        exp_t e;
        int   k;
        e.fc = fc; e.mm = mm; e.lat = lat; e.en = en; e.din = start; e.ec = ec;
        exp_q.push_back(e);
        issue(start, steps, k);
        if (do_pause) begin
            // Now at negedge cyc=k+1; RUN cycles 1 and 2 end at edges k+3, k+4.
            repeat (3) @(negedge clk);
            pause = 1'b1;
            repeat (2) @(negedge clk);
            pause = 1'b0;
        end
        wait_empty();
    endtask

    initial begin
        int k;
        req_if.req_valid = 1'b0;
        req_if.req_start = 8'h00;
        req_if.req_steps = 8'h00;
        #3;
        chk("rst_req_ready", 32'(req_if.req_ready), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_final_count", 32'(final_count), 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        run_job(8'h10, 8'd5, 0, 8'h15, 1'b0, 8, 6, 0);
        run_job(8'hFE, 8'd3, 0, 8'h01, 1'b0, 6, 4, 0);
        run_job(8'h42, 8'd0, 0, 8'h42, 1'b0, 3, 1, 0);
        run_job(8'h20, 8'd4, 1, 8'h24, 1'b0, 9, 5, 0);

        // Second increment is dropped: RUN cycles 3,4 and CHECK miscompare.
        skip_n = 2;
        run_job(8'h00, 8'd4, 0, 8'h03, 1'b1, 7, 5, 3);
        skip_n = 0;
        run_job(8'h7F, 8'd1, 0, 8'h80, 1'b0, 4, 2, 0);

        // Abort a long job mid-RUN.
        issue(8'h10, 8'd20, k);
        repeat (4) @(negedge clk);
        #3;
        rstN = 1'b0;
        #1;
        chk("abort_load", 32'(load), 32'd0);
        chk("abort_enable", 32'(enable), 32'd0);
        chk("abort_data_in", 32'(Data_in), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mismatch", 32'(mismatch), 32'd0);
        chk("abort_final_count", 32'(final_count), 32'd0);
        chk("abort_req_ready", 32'(req_if.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        #3;
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("release_req_ready", 32'(req_if.req_ready), 32'd1);
        repeat (5) @(negedge clk);

        run_job(8'h03, 8'd2, 0, 8'h05, 1'b0, 5, 3, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
